ibex_trace_buffer: RTL and testbench

On-chip retirement trace buffer for the Ibex core, the parametrised successor to the plain RVFI-to-tracer hookup. It filters RVFI retirement records, stores them in a Depth-entry circular buffer and streams them out over a valid/ready port. Three capture modes are supported: streaming, stop-on-full and ring/post-mortem. It instantiates beside ibex_core and consumes the same RVFI signals the tracer uses.

---
 rtl/ibex_trace_buffer_pkg.sv | 20 ++
 rtl/ibex_trace_ring.sv | 56 +++++
 rtl/ibex_trace_buffer.sv | 114 +++++++++++
 tb/tb_ibex_trace_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_trace_buffer_pkg.sv
// Shared types for the retirement trace buffer: capture modes and the stored record layout.
package ibex_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TRACE_STREAM = 2'b00,
        TRACE_STOP   = 2'b01,
        TRACE_RING   = 2'b10
    } trace_mode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
        logic [4:0]  rd_addr;
        logic        intr;
        logic        trap;
        logic [1:0]  mode;
    } trace_rec_t;

endpackage

// File: rtl/ibex_trace_ring.sv
// Circular record store with wrapping pointers and a level counter that separates full from empty.
module ibex_trace_ring
    import ibex_trace_buffer_pkg::*;
#(
    parameter int unsigned Depth = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         overwrite,
    input  trace_rec_t                   wdata,
    output trace_rec_t                   rdata,
    output logic [$clog2(Depth+1)-1:0]   level
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth+1);

    trace_rec_t      mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push || overwrite) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PtrW'(1);
            end
            // An overwrite retires the oldest entry while adding one, so level holds.
            if (pop || overwrite) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            if (push && !pop) begin
                level <= level + LvlW'(1);
            end else if (pop && !push) begin
                level <= level - LvlW'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ibex_trace_buffer.sv
// RVFI retirement trace buffer: filtering, capture-mode control, freeze flag and drop counting.
module ibex_trace_buffer
    import ibex_trace_buffer_pkg::*;
#(
    parameter int unsigned Depth        = 16,
    parameter int unsigned DropCntWidth = 16,
    parameter bit          PcFilterEn   = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         clear_i,
    input  logic [1:0]                   mode_i,
    input  logic                         trap_only_i,
    input  logic [31:0]                  pc_lo_i,
    input  logic [31:0]                  pc_hi_i,
    input  logic                         rvfi_valid,
    input  logic [31:0]                  rvfi_pc_rdata,
    input  logic [31:0]                  rvfi_insn,
    input  logic [31:0]                  rvfi_rd_wdata,
    input  logic [4:0]                   rvfi_rd_addr,
    input  logic                         rvfi_trap,
    input  logic                         rvfi_intr,
    input  logic [1:0]                   rvfi_mode,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [31:0]                  out_pc_o,
    output logic [31:0]                  out_insn_o,
    output logic [31:0]                  out_rd_wdata_o,
    output logic [4:0]                   out_rd_addr_o,
    output logic [3:0]                   out_flags_o,
    output logic [$clog2(Depth+1)-1:0]   level_o,
    output logic [DropCntWidth-1:0]      drop_cnt_o,
    output logic                         frozen_o
);

    localparam int unsigned LvlW = $clog2(Depth+1);

    trace_mode_e             mode;
    trace_rec_t              rec;
    trace_rec_t              head;
    logic [LvlW-1:0]         level;
    logic                    window_active, in_window, eligible, accept;
    logic                    full, pop, push, overwrite, drop, fill;
    logic                    frozen;
    logic [DropCntWidth-1:0] drop_cnt;

    always_comb begin
        case (trace_mode_e'(mode_i))
            TRACE_STOP: mode = TRACE_STOP;
            TRACE_RING: mode = TRACE_RING;
            default:    mode = TRACE_STREAM;
        endcase
    end

    assign rec = '{pc: rvfi_pc_rdata, insn: rvfi_insn, rd_wdata: rvfi_rd_wdata,
                   rd_addr: rvfi_rd_addr, intr: rvfi_intr, trap: rvfi_trap, mode: rvfi_mode};

    assign window_active = PcFilterEn && (pc_lo_i < pc_hi_i);
    assign in_window     = (rvfi_pc_rdata >= pc_lo_i) && (rvfi_pc_rdata < pc_hi_i);
    assign eligible      = rvfi_valid && enable_i && (!trap_only_i || rvfi_trap || rvfi_intr)
                           && (!window_active || in_window);
    assign accept        = eligible && !clear_i;

    // The push is judged after the same-cycle pop, so a popping full buffer still has room.
    assign full      = (level == LvlW'(Depth));
    assign pop       = (level != '0) && out_ready_i;
    assign push      = accept && !frozen && (!full || pop);
    assign overwrite = accept && !frozen && full && !pop && (mode == TRACE_RING);
    assign drop      = accept && (frozen || (full && !pop && (mode != TRACE_RING)));
    assign fill      = push && (pop ? full : (level == LvlW'(Depth-1)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frozen   <= 1'b0;
            drop_cnt <= '0;
        end else if (clear_i) begin
            frozen   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (fill && (mode == TRACE_STOP)) begin
                frozen <= 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DropCntWidth'(1);
            end
        end
    end

    ibex_trace_ring #(
        .Depth (Depth)
    ) u_ring (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (clear_i),
        .push      (push),
        .pop       (pop),
        .overwrite (overwrite),
        .wdata     (rec),
        .rdata     (head),
        .level     (level)
    );

    assign out_valid_o    = (level != '0);
    assign out_pc_o       = head.pc;
    assign out_insn_o     = head.insn;
    assign out_rd_wdata_o = head.rd_wdata;
    assign out_rd_addr_o  = head.rd_addr;
    assign out_flags_o    = {head.intr, head.trap, head.mode};
    assign level_o        = level;
    assign drop_cnt_o     = drop_cnt;
    assign frozen_o       = frozen;

endmodule

// File: tb/tb_ibex_trace_buffer.sv
// Bench for ibex_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_ibex_trace_buffer;
    import ibex_trace_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 2;

    logic        clk = 1'b0;
    logic        rst, enable, clear, trap_only, out_ready;
    logic [1:0]  mode;
    logic [31:0] pc_lo, pc_hi;
    logic        rvfi_valid, rvfi_trap, rvfi_intr;
    logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata;
    logic [4:0]  rvfi_rd_addr;
    logic [1:0]  rvfi_mode;
    logic        out_valid, frozen;
    logic [31:0] out_pc, out_insn, out_rd_wdata;
    logic [4:0]  out_rd_addr;
    logic [3:0]  out_flags;
    logic [2:0]  level;
    logic [DW-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    trace_rec_t q[$];
    int         drops;
    bit         frozen_m;

    ibex_trace_buffer #(.Depth(DEPTH), .DropCntWidth(DW), .PcFilterEn(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear), .mode_i(mode),
        .trap_only_i(trap_only), .pc_lo_i(pc_lo), .pc_hi_i(pc_hi),
        .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_trap(rvfi_trap),
        .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
        .out_insn_o(out_insn), .out_rd_wdata_o(out_rd_wdata), .out_rd_addr_o(out_rd_addr),
        .out_flags_o(out_flags), .level_o(level), .drop_cnt_o(drop_cnt), .frozen_o(frozen)
    );

    always #5 clk = ~clk;

    function automatic int sat_inc(input int v);
        return (v < (1 << DW) - 1) ? v + 1 : v;
    endfunction

    // Reference: pop first, then the candidate either joins, overwrites the oldest, or is lost.
    task automatic model_step();
        trace_rec_t r;
        bit win, elig;
        r = '{pc: rvfi_pc_rdata, insn: rvfi_insn, rd_wdata: rvfi_rd_wdata, rd_addr: rvfi_rd_addr,
              intr: rvfi_intr, trap: rvfi_trap, mode: rvfi_mode};
        win  = (pc_lo < pc_hi) ? (rvfi_pc_rdata >= pc_lo && rvfi_pc_rdata < pc_hi) : 1'b1;
        elig = rvfi_valid && enable && (!trap_only || rvfi_trap || rvfi_intr) && win;
        if (clear) begin
            q.delete();
            drops    = 0;
            frozen_m = 0;
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (elig) begin
                if (frozen_m) drops = sat_inc(drops);
                else if (q.size() < DEPTH) begin
                    q.push_back(r);
                    if (mode == 2'b01 && q.size() == DEPTH) frozen_m = 1;
                end else if (mode == 2'b10) begin
                    void'(q.pop_front());
                    q.push_back(r);
                end else drops = sat_inc(drops);
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic trap, input logic intr);
        rvfi_valid    = 1'b1;
        rvfi_pc_rdata = pc;
        rvfi_insn     = $urandom;
        rvfi_rd_wdata = $urandom;
        rvfi_rd_addr  = 5'($urandom);
        rvfi_trap     = trap;
        rvfi_intr     = intr;
        rvfi_mode     = 2'($urandom);
        step();
        rvfi_valid    = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; clear = 1'b0; mode = 2'b00; trap_only = 1'b0;
        pc_lo = '0; pc_hi = '0; out_ready = 1'b0; rvfi_valid = 1'b0; rvfi_pc_rdata = '0;
        rvfi_insn = '0; rvfi_rd_wdata = '0; rvfi_rd_addr = '0; rvfi_trap = 1'b0;
        rvfi_intr = 1'b0; rvfi_mode = '0;
        q.delete(); drops = 0; frozen_m = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || level !== 3'd0 || drop_cnt !== 2'd0 || frozen !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got v=%b lvl=%0d drop=%0d frz=%b exp 0/0/0/0",
                     out_valid, level, drop_cnt, frozen);
        end
        total++;
        if ({out_pc, out_insn, out_rd_wdata, out_rd_addr, out_flags} !== 105'd0) begin
            bad++;
            $display("FAIL reset_data got pc=%h insn=%h exp 0", out_pc, out_insn);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        mode = 2'b00; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'(32'h100 + 4 * i), 1'b0, 1'b0);
        total++;
        if (level !== 3'd4 || drop_cnt !== 2'd2) begin
            bad++;
            $display("FAIL stream_fill got lvl=%0d drop=%0d exp 4/2", level, drop_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(32'h100 + 4 * i)) begin
                bad++;
                $display("FAIL stream_drain%0d got v=%b pc=%h exp pc=%h", i, out_valid, out_pc,
                         32'(32'h100 + 4 * i));
            end
            step();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            bad++;
            $display("FAIL stream_empty got v=%b lvl=%0d exp 0/0", out_valid, level);
        end
    endtask

    task automatic test_stop();
        do_clear();
        mode = 2'b01;
        for (int i = 0; i < 4; i++) send(32'(32'h300 + 4 * i), 1'b0, 1'b0);
        total++;
        if (frozen !== 1'b1 || level !== 3'd4) begin
            bad++;
            $display("FAIL stop_freeze got frz=%b lvl=%0d exp 1/4", frozen, level);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_pc !== 32'(32'h300 + 4 * i)) begin
                bad++;
                $display("FAIL stop_drain%0d got pc=%h exp %h", i, out_pc, 32'(32'h300 + 4 * i));
            end
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'(32'h400 + 4 * i), 1'b0, 1'b0);
        total++;
        if (level !== 3'd0 || drop_cnt !== 2'd3 || frozen !== 1'b1) begin
            bad++;
            $display("FAIL stop_frozen_drops got lvl=%0d drop=%0d frz=%b exp 0/3/1",
                     level, drop_cnt, frozen);
        end
        do_clear();
        total++;
        if (frozen !== 1'b0 || drop_cnt !== 2'd0) begin
            bad++;
            $display("FAIL stop_clear got frz=%b drop=%0d exp 0/0", frozen, drop_cnt);
        end
    endtask

    task automatic test_ring();
        do_clear();
        mode = 2'b10; out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(32'(4 * i), 1'b0, 1'b0);
        total++;
        if (level !== 3'd4 || drop_cnt !== 2'd0) begin
            bad++;
            $display("FAIL ring_fill got lvl=%0d drop=%0d exp 4/0", level, drop_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_pc !== 32'(12 + 4 * i)) begin
                bad++;
                $display("FAIL ring_drain%0d got pc=%h exp %h", i, out_pc, 32'(12 + 4 * i));
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_filter();
        do_clear();
        mode = 2'b00; trap_only = 1'b1; pc_lo = 32'h200; pc_hi = 32'h300;
        send(32'h1FC, 1'b1, 1'b0);
        send(32'h204, 1'b0, 1'b0);
        send(32'h208, 1'b0, 1'b1);
        total++;
        if (level !== 3'd1 || out_pc !== 32'h208 || out_flags[3] !== 1'b1 || drop_cnt !== 2'd0) begin
            bad++;
            $display("FAIL filter_window got lvl=%0d pc=%h intr=%b exp 1/208/1",
                     level, out_pc, out_flags[3]);
        end
        do_clear();
        pc_lo = 32'h200; pc_hi = 32'h200;
        send(32'h1FC, 1'b1, 1'b0);
        send(32'h500, 1'b1, 1'b0);
        send(32'h204, 1'b0, 1'b0);
        total++;
        if (level !== 3'd2 || out_pc !== 32'h1FC || out_flags[2] !== 1'b1) begin
            bad++;
            $display("FAIL filter_nowindow got lvl=%0d pc=%h exp 2/1fc", level, out_pc);
        end
        trap_only = 1'b0; pc_lo = '0; pc_hi = '0;
    endtask

    task automatic test_back_to_back();
        do_clear();
        mode = 2'b00; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(32'h40 + 4 * i), 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_pc !== 32'(32'h40 + 4 * i)) begin
                bad++;
                $display("FAIL b2b_head%0d got pc=%h exp %h", i, out_pc, 32'(32'h40 + 4 * i));
            end
            send(32'(32'h50 + 4 * i), 1'b0, 1'b0);
            total++;
            if (level !== 3'd4 || drop_cnt !== 2'd0) begin
                bad++;
                $display("FAIL b2b_level%0d got lvl=%0d drop=%0d exp 4/0", i, level, drop_cnt);
            end
        end
        total++;
        if (out_pc !== 32'h50) begin
            bad++;
            $display("FAIL b2b_order got pc=%h exp 50", out_pc);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'(32'h80 + 4 * i), 1'b0, 1'b0);
        total++;
        if (drop_cnt !== 2'd3 || level !== 3'd4) begin
            bad++;
            $display("FAIL drop_saturate got drop=%0d lvl=%0d exp 3/4", drop_cnt, level);
        end
    endtask

    task automatic test_clear_concurrent();
        clear = 1'b1; out_ready = 1'b1;
        send(32'h900, 1'b0, 1'b0);
        clear = 1'b0; out_ready = 1'b0;
        total++;
        if (level !== 3'd0 || out_valid !== 1'b0 || drop_cnt !== 2'd0) begin
            bad++;
            $display("FAIL clear_concurrent got lvl=%0d v=%b drop=%0d exp 0/0/0",
                     level, out_valid, drop_cnt);
        end
    endtask

    task automatic test_random();
        int unsigned lo;
        do_clear();
        for (int n = 0; n < 600; n++) begin
            clear      = ($urandom_range(0, 99) < 2);
            mode       = 2'($urandom);
            enable     = ($urandom_range(0, 9) != 0);
            trap_only  = ($urandom_range(0, 4) == 0);
            out_ready  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) begin
                lo    = $urandom_range(0, 32'h200);
                pc_lo = lo;
                pc_hi = lo + $urandom_range(0, 32'h200);
            end else begin
                pc_lo = '0; pc_hi = '0;
            end
            rvfi_valid    = ($urandom_range(0, 3) != 0);
            rvfi_pc_rdata = $urandom_range(0, 32'h3FF) & 32'hFFFF_FFFC;
            rvfi_insn     = $urandom;
            rvfi_rd_wdata = $urandom;
            rvfi_rd_addr  = 5'($urandom);
            rvfi_trap     = ($urandom_range(0, 3) == 0);
            rvfi_intr     = ($urandom_range(0, 7) == 0);
            rvfi_mode     = 2'($urandom);
            step();
            total++;
            if (out_valid !== (q.size() > 0) || level !== 3'(q.size()) ||
                drop_cnt !== DW'(drops) || frozen !== frozen_m) begin
                bad++;
                $display("FAIL rand_ctrl cyc=%0d got v=%b lvl=%0d drop=%0d frz=%b exp lvl=%0d drop=%0d frz=%b",
                         n, out_valid, level, drop_cnt, frozen, q.size(), drops, frozen_m);
            end
            if (q.size() > 0) begin
                total++;
                if ({out_pc, out_insn, out_rd_wdata, out_rd_addr, out_flags} !== q[0]) begin
                    bad++;
                    $display("FAIL rand_head cyc=%0d got pc=%h insn=%h exp pc=%h insn=%h",
                             n, out_pc, out_insn, q[0].pc, q[0].insn);
                end
            end
        end
        clear = 1'b0; rvfi_valid = 1'b0; enable = 1'b1; trap_only = 1'b0;
        pc_lo = '0; pc_hi = '0; out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        mode = 2'b01;
        for (int i = 0; i < 4; i++) send(32'(32'hA00 + 4 * i), 1'b0, 1'b0);
        send(32'hB00, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        q.delete(); drops = 0; frozen_m = 0;
        total++;
        if (out_valid !== 1'b0 || level !== 3'd0 || drop_cnt !== 2'd0 || frozen !== 1'b0 ||
            out_pc !== 32'd0) begin
            bad++;
            $display("FAIL async_reset got v=%b lvl=%0d drop=%0d frz=%b pc=%h exp all 0",
                     out_valid, level, drop_cnt, frozen, out_pc);
        end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stop();
        test_ring();
        test_filter();
        test_back_to_back();
        test_clear_concurrent();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
